// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store requester: access sizes,
// FSM states and the alignment rule applied at accept.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    // Illegal size or an address that is not naturally aligned for the size.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Big-endian byte/half lane handling: load extract with sign/zero extension
// and store merge of new data into an old word. Purely combinational.
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shift     = 5'd0;
        mask      = 32'hFFFF_FFFF;
        // Offset 0 is the most significant lane, so the shift is (3-off)*8 for
        // bytes and (2-off)*8 for halves.
        case (size)
            SZ_BYTE: begin
                shift = {~offset, 3'b000};
                mask  = 32'h0000_00FF << shift;
            end
            SZ_HALF: begin
                shift = {~offset[1], 4'b0000};
                mask  = 32'h0000_FFFF << shift;
            end
            default: begin
                shift = 5'd0;
                mask  = 32'hFFFF_FFFF;
            end
        endcase

        shifted = word >> shift;

        case (size)
            SZ_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase

        merged = (word & ~mask) | ((new_data << shift) & mask);
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store requester driving the word-wide dm port; sub-word
// stores are done as read-modify-write, sub-word loads are lane-extracted.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    state_t              state_reg, state_next;
    logic                we_reg;
    logic [1:0]          size_reg;
    logic                signed_reg;
    logic [ADDR_W+1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   merge_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;

    logic                accept;
    logic                bad_req;
    logic [31:0]         load_data;
    logic [31:0]         merged;

    assign req_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign accept    = req_valid && req_ready;
    assign bad_req   = is_bad_access(req_size, req_addr[1:0]);

    mem_lane u_lane (
        .word      (dm_rdata),
        .offset    (addr_reg[1:0]),
        .size      (size_reg),
        .is_signed (signed_reg),
        .new_data  (wdata_reg),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (bad_req)               state_next = DONE;
                    else if (!req_we)          state_next = RD;
                    else if (req_size == SZ_WORD) state_next = WR;
                    else                       state_next = RMW_RD;
                end else begin
                    state_next = IDLE;
                end
            end
            RD:      state_next = DONE;
            WR:      state_next = DONE;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // dm and response outputs come only from registered state and data.
    always_comb begin
        dm_addr    = '0;
        dm_rd      = 1'b0;
        dm_wr      = 1'b0;
        dm_wdata   = '0;
        resp_valid = 1'b0;
        case (state_reg)
            RD: begin
                dm_addr = addr_reg[ADDR_W+1:2];
                dm_rd   = 1'b1;
            end
            WR: begin
                dm_addr  = addr_reg[ADDR_W+1:2];
                dm_wr    = 1'b1;
                dm_wdata = wdata_reg;
            end
            RMW_RD: begin
                dm_addr = addr_reg[ADDR_W+1:2];
                dm_rd   = 1'b1;
            end
            RMW_WR: begin
                dm_addr  = addr_reg[ADDR_W+1:2];
                dm_wr    = 1'b1;
                dm_wdata = merge_reg;
            end
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg     <= 1'b0;
            size_reg   <= SZ_BYTE;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            merge_reg  <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                we_reg     <= req_we;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
            if (state_reg == RMW_RD) begin
                merge_reg <= merged;
            end
            // Response fields change only on entry to DONE so they stay stable
            // from one response pulse to the next.
            if (state_next == DONE) begin
                rdata_reg <= (state_reg == RD && !we_reg) ? load_data : '0;
                err_reg   <= (state_reg == IDLE) || (state_reg == DONE);
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access paired with a behavioural dm array and a
// byte-addressed big-endian reference memory.
module tb_mem_access;

    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_rd;
    logic              dm_wr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dm_mem    [0:(1<<ADDR_W)-1];
    logic [7:0]  ref_bytes [0:(4<<ADDR_W)-1];

    mem_access #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_rd      (dm_rd),
        .dm_wr      (dm_wr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dm: combinational read, write at the rising edge ending a dm_wr cycle
    assign dm_rdata = dm_mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wr) dm_mem[dm_addr] <= dm_wdata;
    end

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_bytes[4*widx], ref_bytes[4*widx+1], ref_bytes[4*widx+2], ref_bytes[4*widx+3]};
    endfunction

    // Run one request through the DUT and compare against the byte-level model.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [ADDR_W+1:0] addr, input logic [31:0] wdata);
        int          a;
        int          nbytes;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_rdata;
        logic [31:0] raw;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic        addr_bad;
        a = int'(addr);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_req: got %b expected 1", req_ready);
        end
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = (ADDR_W+2)'($urandom);
        req_wdata  = $urandom;

        exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        nbytes  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_rdata = 32'h0;
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            raw = 32'h0;
            for (int i = 0; i < nbytes; i++) raw = (raw << 8) | 32'(ref_bytes[a+i]);
            if (sgn && nbytes == 1)      exp_rdata = 32'($signed(raw[7:0]));
            else if (sgn && nbytes == 2) exp_rdata = 32'($signed(raw[15:0]));
            else                         exp_rdata = raw;
        end else begin
            exp_lat = (nbytes == 4) ? 2 : 3;
            exp_rd  = (nbytes == 4) ? 0 : 1;
            exp_wr  = 1;
            for (int i = 0; i < nbytes; i++) ref_bytes[a+i] = 8'(wdata >> (8*(nbytes-1-i)));
        end

        lat = 0; n_rd = 0; n_wr = 0; addr_bad = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dm_rd) n_rd++;
            if (dm_wr) n_wr++;
            if ((dm_rd || dm_wr) && dm_addr !== addr[ADDR_W+1:2]) addr_bad = 1'b1;
            if (resp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end

        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL latency: got %0d expected %0d (addr %h size %0d we %0d)", lat, exp_lat, addr, size, we);
        end
        checks++;
        if (resp_err !== exp_err) begin
            failures++;
            $display("FAIL resp_err: got %b expected %b (addr %h size %0d)", resp_err, exp_err, addr, size);
        end
        checks++;
        if (resp_rdata !== exp_rdata) begin
            failures++;
            $display("FAIL resp_rdata: got %h expected %h (addr %h size %0d signed %0d)", resp_rdata, exp_rdata, addr, size, sgn);
        end
        checks++;
        if (n_rd != exp_rd || n_wr != exp_wr) begin
            failures++;
            $display("FAIL dm_cycles: got rd=%0d wr=%0d expected rd=%0d wr=%0d", n_rd, n_wr, exp_rd, exp_wr);
        end
        checks++;
        if (addr_bad || dm_addr !== '0) begin
            failures++;
            $display("FAIL dm_addr: got bad=%b done_addr=%h expected bad=0 done_addr=0", addr_bad, dm_addr);
        end
        checks++;
        if (dm_mem[a/4] !== ref_word(a/4)) begin
            failures++;
            $display("FAIL mem_word: got %h expected %h (word %0d)", dm_mem[a/4], ref_word(a/4), a/4);
        end
        // One cycle later the response must be gone but its data held.
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== exp_rdata || resp_err !== exp_err) begin
            failures++;
            $display("FAIL resp_hold: got valid=%b rdata=%h err=%b expected valid=0 rdata=%h err=%b",
                     resp_valid, resp_rdata, resp_err, exp_rdata, exp_err);
        end
        $display("txn we=%0d size=%0d signed=%0d addr=%h wdata=%h -> lat=%0d err=%b rdata=%h",
                 we, size, sgn, addr, wdata, lat, resp_err, resp_rdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < (1<<ADDR_W); i++) dm_mem[i] = 32'h0;
        for (int i = 0; i < (4<<ADDR_W); i++) ref_bytes[i] = 8'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            dm_addr !== '0 || dm_rd !== 1'b0 || dm_wr !== 1'b0 || dm_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h addr=%h rd=%b wr=%b wdata=%h expected 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_err, resp_rdata, dm_addr, dm_rd, dm_wr, dm_wdata);
        end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 9'h000, 32'hABCDEF01);
        do_req(1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    endtask

    task automatic test_subword_loads();
        do_req(1'b0, 2'b00, 1'b1, 9'h001, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 9'h001, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 9'h002, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 9'h000, 32'h0);
    endtask

    task automatic test_rmw();
        do_req(1'b1, 2'b10, 1'b0, 9'h004, 32'hFFFFAAAA);
        do_req(1'b1, 2'b01, 1'b0, 9'h006, 32'h00001234);
        checks++;
        if (dm_mem[1] !== 32'hFFFF1234) begin
            failures++;
            $display("FAIL sh_merge: got %h expected FFFF1234", dm_mem[1]);
        end
        do_req(1'b1, 2'b00, 1'b0, 9'h004, 32'h00000077);
        checks++;
        if (dm_mem[1] !== 32'h77FF1234) begin
            failures++;
            $display("FAIL sb_merge: got %h expected 77FF1234", dm_mem[1]);
        end
    endtask

    task automatic test_errors();
        do_req(1'b0, 2'b10, 1'b0, 9'h002, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 9'h003, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 9'h004, 32'hDEADBEEF);
        do_req(1'b1, 2'b10, 1'b0, 9'h005, 32'hDEADBEEF);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 9'h008; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_addr = 9'h008; req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) ref_bytes[8+i] = 8'(32'h11223344 >> (24 - 8*i));
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || dm_wr !== 1'b1 || dm_wdata !== 32'h11223344) begin
            failures++;
            $display("FAIL b2b_store: got ready=%b wr=%b wdata=%h expected 0,1,11223344", req_ready, dm_wr, dm_wdata);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got valid=%b ready=%b expected 1,1", resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_rd !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load_rd: got rd=%b valid=%b expected 1,0", dm_rd, resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== ref_word(2) || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load: got valid=%b rdata=%h err=%b expected 1,%h,0", resp_valid, resp_rdata, resp_err, ref_word(2));
        end
        $display("txn back-to-back sw/lw 0x008 -> rdata=%h", resp_rdata);
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] old_word;
        old_word = ref_word(0);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 9'h000; req_wdata = 32'h00000055;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_rd !== 1'b1) begin
            failures++;
            $display("FAIL rmw_rd_phase: got rd=%b expected 1", dm_rd);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            dm_addr !== '0 || dm_rd !== 1'b0 || dm_wr !== 1'b0 || dm_wdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got ready=%b valid=%b err=%b rdata=%h addr=%h rd=%b wr=%b wdata=%h expected 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_err, resp_rdata, dm_addr, dm_rd, dm_wr, dm_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dm_wr !== 1'b0 || dm_mem[0] !== old_word) begin
            failures++;
            $display("FAIL aborted_rmw: got wr=%b word0=%h expected 0,%h", dm_wr, dm_mem[0], old_word);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: got ready=%b valid=%b expected 1,0", req_ready, resp_valid);
        end
        $display("txn reset during RMW sb 0x000 -> word0=%h", dm_mem[0]);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int n = 0; n < 150; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), sz, 1'($urandom), 9'($urandom_range(0, 31)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_loads();
        test_rmw();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store requester for the MEM stage of the five-stage MIPS CPU; it is the initiator side of the `dm` word-wide data memory port. It accepts one byte-addressed load or store from the pipeline at a time and drives `dm`'s `addr`/`rd`/`wr`/`wdata`/`rdata` interface. Sub-word accesses are handled internally:

- Loads: lane extraction plus sign/zero extension.
- Stores: read-modify-write.

It returns a one-cycle response pulse, and the pipeline stalls while `req_ready` is low.

## Interface

Parameters:

- `ADDR_W`, 7: `dm` word-address width; the byte address is `ADDR_W+2` bits.
- `DATA_W`, 32: word width; only 32 is supported.

Ports:

- Clock and reset:
  - `clk` in 1: single clock, rising edge.
  - `rst_n` in 1: reset, asynchronous and active-low.
- Request side:
  - `req_valid` in 1: request present.
  - `req_ready` out 1: block idle, can accept.
  - `req_we` in 1: 1 = store, 0 = load.
  - `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
  - `req_signed` in 1: sign-extend sub-word loads.
  - `req_addr` in `ADDR_W+2`: byte address.
  - `req_wdata` in 32: store data, right-justified.
- Response side:
  - `resp_valid` out 1: one-cycle completion pulse.
  - `resp_rdata` out 32: load result; 0 for stores and errors.
  - `resp_err` out 1: misaligned/illegal request; valid with `resp_valid`.
- `dm` side:
  - `dm_addr` out `ADDR_W`: word address to `dm`.
  - `dm_rd` out 1: `dm` read enable.
  - `dm_wr` out 1: `dm` write enable.
  - `dm_wdata` out 32: `dm` write data.
  - `dm_rdata` in 32: `dm` read data, combinational from `addr`/`rd`.

## Operation

- Byte order is big-endian:
  - Byte offset 0 = bits 31:24.
  - Halfword offset 0 = bits 31:16.
- `dm` contract: reads are combinational in the cycle `dm_rd`=1; the write commits at the rising edge ending a cycle with `dm_wr`=1.
- A request is accepted on a rising edge with `req_valid && req_ready`. All request fields are latched at that edge; inputs are ignored afterwards.
- Alignment check happens at accept. A request is an error if any of these hold:
  - size 11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
  - IDLE: `req_ready`=1. Accepting moves to one of:
    - error → DONE;
    - load → RD;
    - word store → WR;
    - byte/half store → RMW_RD.
  - RD: `dm_rd`=1. The extracted/extended lane is registered into `resp_rdata`. → DONE.
  - WR: `dm_wr`=1, `dm_wdata`=`req_wdata`. → DONE.
  - RMW_RD: `dm_rd`=1. A merge register ← `dm_rdata` with the addressed lane(s) replaced by the low byte/half of the latched wdata. → RMW_WR.
  - RMW_WR: `dm_wr`=1, `dm_wdata`=merge register. → DONE.
  - DONE: `resp_valid`=1 and `req_ready`=1 (behaves as IDLE for accept), so back-to-back requests are accepted with no bubble. → next state per accept, else IDLE.
- `dm_addr` = latched `req_addr[ADDR_W+1:2]` in all non-idle states. It is 0 in IDLE/DONE.
- `dm_rd`, `dm_wr`, `dm_wdata` and `resp_*` are decoded from registered state/data only; no combinational path from `req_*`.
- Errors make no `dm` access: `dm_rd`/`dm_wr` stay 0, `resp_rdata`=0, `resp_err`=1.
- `resp_err` and `resp_rdata` are held until the next `resp_valid`.

## Timing

- Latency, measured from the accept edge to the `resp_valid` cycle, counted in cycles after accept:
  - error: 1;
  - load: 2;
  - word store: 2;
  - sub-word store: 3.
- Throughput: one request per latency period; DONE overlaps the next accept.
- Exactly one `dm_wr` cycle per store, zero per load or error.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `dm_addr`=0, `dm_rd`=0, `dm_wr`=0, `dm_wdata`=0.
- Reset mid-operation: asynchronous assertion clears all outputs immediately.
  - An in-flight RMW is aborted with no write; `dm` content is unchanged.
  - No response is produced for the aborted request.
- A `req_valid` held while `req_ready`=0 is not accepted and may change freely.

## Structure

- Package `mem_access_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the FSM state enum.
- Sub-module `mem_lane`: purely combinational.
  - Load extract/extend: word, offset, size, signed → 32-bit result.
  - Store merge: old word, new data, offset, size → merged word.
  - Both RD and RMW_RD paths use it.
- Top-level `mem_access`: FSM, latches, output decode; instantiates `mem_lane`.
- Bench pairs `mem_access` with the existing `dm`.

## Test plan

- Word store then load: sw `0x000` = ABCDEF01 → one `dm_wr` cycle at `dm_addr` 0, `resp_valid` 2 cycles after accept; lw `0x000` → `resp_rdata` ABCDEF01, `resp_err`=0.
- Sub-word loads on word 0 = ABCDEF01:
  - lb `0x001` → FFFFFFCD.
  - lbu `0x001` → 000000CD.
  - lh `0x002` → FFFFEF01.
  - lhu `0x000` → 0000ABCD.
- RMW store: word 1 = FFFFAAAA, sh `0x006` wdata 00001234 → exactly one `dm_rd` then one `dm_wr` cycle, `resp_valid` at +3, word 1 = FFFF1234; sb `0x004` wdata 00000077 → word 1 = 77FF1234.
- Errors: lw `0x002`, lh `0x003`, size 11 → `resp_valid`+`resp_err`=1 at +1, `resp_rdata`=0, `dm_rd`/`dm_wr` never asserted, memory unchanged.
- Back-to-back: `req_valid` held high with sw `0x008` = 11223344 then lw `0x008` → second accepted in the first's DONE cycle; load returns 11223344 at accept+2.
- Reset in RMW_RD of sb `0x000` = 00000055 → outputs clear immediately, no `dm_wr`, word 0 unchanged; `req_ready`=1 after `rst_n` rises.
